// File: rtl/pattern_sweep_pkg.sv
// pattern_sweep_pkg: shared FSM states, step count and stimulus pattern helper
// Contents: state_e (IDLE/DRIVE/FIN), NUM_STEPS, MAX_W, rep_step()
package pattern_sweep_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FIN   = 2'd2
    } state_e;
    localparam int NUM_STEPS = 16;
    localparam int MAX_W = 1024;
    // Step nibble replicated across the widest supported bus; callers cast down to W.
    function automatic logic [MAX_W-1:0] rep_step(input logic [3:0] step);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W / 4; i++) r[4*i +: 4] = step;
        return r;
    endfunction
endpackage

// File: rtl/pattern_sweep_checker_dwell_timer.sv
// dwell_timer: loadable up-counter pulsing tc_o on the last cycle of each DWELL-cycle step
// Ports: clk_i, rst_ni (async active-low), load_i (clear count), en_i (count), tc_o (terminal count)
module dwell_timer #(
    parameter int DWELL = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(DWELL);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tc_o  = en_i && !load_i && cnt_q == CW'(DWELL - 1);
    assign cnt_d = (load_i || tc_o) ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pattern_sweep_checker.sv
// pattern_sweep_checker: sweeps 16 replicated-nibble patterns onto SW_OUT and checks LED_IN echoes them
// Ports: CLK, RST_N (async active-low), START, SW_OUT (stimulus), LED_IN (response),
//        BUSY (sweeping), DONE/PASS (result), ERR_CNT (mismatching steps), FIRST_ERR (first bad step)
module pattern_sweep_checker
    import pattern_sweep_pkg::*;
#(
    parameter int DWELL = 10,
    parameter int W = 12
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [W-1:0] LED_IN,
    output logic [W-1:0] SW_OUT,
    output logic         BUSY,
    output logic         DONE,
    output logic         PASS,
    output logic [4:0]   ERR_CNT,
    output logic [3:0]   FIRST_ERR
);
    state_e state_q, state_d;
    logic [3:0] step_q, step_d, first_q, first_d;
    logic [4:0] err_q, err_d;
    logic [W-1:0] sw_q, sw_d;
    logic done_q, done_d, pass_q, pass_d;
    logic load, tc, miss;
    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk_i (CLK),
        .rst_ni(RST_N),
        .load_i(load),
        .en_i  (state_q == ST_DRIVE),
        .tc_o  (tc)
    );
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        first_d = first_q;
        load    = 1'b0;
        miss    = LED_IN != sw_q;
        case (state_q)
            ST_IDLE, ST_FIN: if (START) begin
                state_d = ST_DRIVE;
                step_d  = '0;
                err_d   = '0;
                first_d = '0;
                load    = 1'b1;
            end
            ST_DRIVE: if (tc) begin
                // step wraps 15->0 on the same edge that enters FIN
                step_d = step_q + 4'd1;
                if (miss) begin
                    err_d = err_q + 5'd1;
                    if (err_q == '0) first_d = step_q;
                end
                if (step_q == 4'(NUM_STEPS - 1)) state_d = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
        // outputs are registered from next-state so SW_OUT changes exactly on step boundaries
        sw_d   = state_d == ST_DRIVE ? W'(rep_step(step_d)) : '0;
        done_d = state_d == ST_FIN;
        pass_d = state_d == ST_FIN && err_d == '0;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            sw_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
            first_q <= first_d;
            sw_q    <= sw_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end
    assign SW_OUT    = sw_q;
    assign BUSY      = state_q == ST_DRIVE;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_CNT   = err_q;
    assign FIRST_ERR = first_q;
endmodule

// File: tb/tb_pattern_sweep_checker.sv
// tb_pattern_sweep_checker: scoreboard bench for DWELL=10 and DWELL=2 checkers
module tb_pattern_sweep_checker;
    localparam int W = 12;
    typedef struct {
        int err;
        int first;
        bit pass;
    } exp_t;
    logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
    bit sel = 1'b0;
    int tests = 0, fails = 0;
    exp_t q[$];
    int md = 0, gl = 0;
    logic [W-1:0] mk = '1, xv = '0;
    logic [15:0] xm = '0;
    int sc = -1;
    int dw;
    assign dw = sel ? 2 : 10;
    logic [W-1:0] sw_a, sw_b, led_a, led_b, sw;
    logic busy_a, busy_b, done_a, done_b, pass_a, pass_b, busy, done, pass;
    logic [4:0] err_a, err_b, errc;
    logic [3:0] first_a, first_b, first;
    wire cmp = sc >= 0 && sc < 16 * dw && (sc % dw) == dw - 1;

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] rep(input int s);
        logic [3:0] n;
        n = 4'(s);
        return {3{n}};
    endfunction

    // How the simulated LEDs deviate from the switches: 1 stuck mask, 2 zero glitch on
    // one step's compare cycle, 3 xor flip on compare cycles of selected steps.
    function automatic logic [W-1:0] corrupt(input logic [W-1:0] v, input int m, input logic [W-1:0] mask,
                                             input int g, input logic [15:0] xmask, input logic [W-1:0] xval,
                                             input int s, input bit c);
        logic [3:0] si;
        si = 4'(s);
        if (m == 1) return v & mask;
        if (m == 2 && c && s == g) return '0;
        if (m == 3 && c && xmask[si]) return v ^ xval;
        return v;
    endfunction

    assign led_a = sel ? sw_a : corrupt(sw_a, md, mk, gl, xm, xv, sc / dw, cmp);
    assign led_b = sel ? corrupt(sw_b, md, mk, gl, xm, xv, sc / dw, cmp) : sw_b;
    assign sw    = sel ? sw_b : sw_a;
    assign busy  = sel ? busy_b : busy_a;
    assign done  = sel ? done_b : done_a;
    assign pass  = sel ? pass_b : pass_a;
    assign errc  = sel ? err_b : err_a;
    assign first = sel ? first_b : first_a;

    pattern_sweep_checker #(.DWELL(10), .W(W)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SW_OUT(sw_a), .LED_IN(led_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a), .FIRST_ERR(first_a)
    );
    pattern_sweep_checker #(.DWELL(2), .W(W)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SW_OUT(sw_b), .LED_IN(led_b),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b), .FIRST_ERR(first_b)
    );

    // Timeline: sc = cycles since the first DRIVE cycle, -1 when idle; START is ignored mid-sweep.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sc <= -1;
        else if (START && (sc < 0 || sc >= 16 * dw)) sc <= 0;
        else if (sc >= 0 && sc < 16 * dw) sc <= sc + 1;
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (sc=%0d dwell=%0d)", n, a, x, sc, dw);
        end
    endtask

    bit done_prev = 1'b0;
    exp_t e_mon;
    always @(negedge CLK) begin
        if (!RST_N) chk("reset_outputs", {sw, busy, done, pass, errc, first}, 64'd0);
        else begin
            chk("sw_out", sw, (sc >= 0 && sc < 16 * dw) ? rep(sc / dw) : '0);
            chk("busy", busy, sc >= 0 && sc < 16 * dw);
            chk("done", done, sc >= 16 * dw);
            if (sc == 0) chk("clear_on_start", {errc, first, pass}, 64'd0);
            if (done && !done_prev) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got DONE=1 expected no completion pending");
                end else begin
                    e_mon = q.pop_front();
                    chk("err_cnt", errc, e_mon.err);
                    chk("first_err", first, e_mon.first);
                    chk("pass", pass, e_mon.pass);
                end
            end
        end
        done_prev = done;
    end

    task automatic run_sweep(input int m, input logic [W-1:0] mask, input int g, input logic [15:0] xmask,
                             input logic [W-1:0] xval, input int restart_at, input int reset_at);
        exp_t e;
        int err, fst;
        logic [W-1:0] pat;
        err = 0;
        fst = 0;
        md = m; mk = mask; gl = g; xm = xmask; xv = xval;
        for (int s = 0; s < 16; s++) begin
            pat = rep(s);
            if (corrupt(pat, m, mask, g, xmask, xval, s, 1'b1) != pat) begin
                if (err == 0) fst = s;
                err++;
            end
        end
        e.err = err;
        e.first = fst;
        e.pass = err == 0;
        q.push_back(e);
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        for (int i = 0; i < 16 * dw + 20 && q.size() != 0; i++) begin
            @(negedge CLK);
            START = sc == restart_at;
            if (sc == reset_at) begin
                @(posedge CLK);
                #2 RST_N = 1'b0;
                q.delete();
                repeat (3) @(posedge CLK);
                #2 RST_N = 1'b1;
                START = 1'b0;
                return;
            end
        end
        START = 1'b0;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sweep_timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        repeat ($urandom_range(0, 5)) @(negedge CLK);
    endtask

    task automatic random_sweeps(input int n);
        for (int k = 0; k < n; k++)
            run_sweep($urandom_range(0, 3), W'($urandom), $urandom_range(0, 15), 16'($urandom),
                      W'($urandom_range(1, 4095)), -100, -100);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        run_sweep(0, '1, 0, '0, '0, -100, -100);
        run_sweep(1, 12'h7FF, 0, '0, '0, -100, -100);
        run_sweep(2, '1, 3, '0, '0, -100, -100);
        run_sweep(0, '1, 0, '0, '0, 50, -100);
        run_sweep(0, '1, 0, '0, '0, -100, 70);
        run_sweep(0, '1, 0, '0, '0, -100, -100);
        random_sweeps(6);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        sel = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        run_sweep(0, '1, 0, '0, '0, -100, -100);
        run_sweep(1, 12'h7FF, 0, '0, '0, -100, -100);
        random_sweeps(6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1);
    end
endmodule

// File: doc/pattern_sweep_checker.md
PATTERN_SWEEP_CHECKER -- requirements
Module: pattern_sweep_checker

Interface
REQ-001 SHALL have parameter DWELL, default 10, clock cycles each pattern step is held on SW_OUT (legal range 2..1023).
REQ-002 SHALL have parameter W, default 12, width of the switch/LED bus, a multiple of 4.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  begin a sweep when sampled high in IDLE or DONE state.
REQ-006 SHALL have port SW_OUT  output  W  registered stimulus pattern driven toward the DUT switch inputs.
REQ-007 SHALL have port LED_IN  input  W  DUT LED response, synchronous to CLK.
REQ-008 SHALL have port BUSY  output  1  high while a sweep is in progress.
REQ-009 SHALL have port DONE  output  1  high from sweep completion until next START or reset.
REQ-010 SHALL have port PASS  output  1  valid when DONE; high iff zero mismatches.
REQ-011 SHALL have port ERR_CNT  output  5  mismatching steps in the current or last sweep (0..16).
REQ-012 SHALL have port FIRST_ERR  output  4  step index of the first mismatch; 0 when ERR_CNT is 0.

Function
REQ-013 SHALL implement states IDLE, DRIVE, FIN; state encoding belongs in the package.
REQ-014 SHALL, on START in IDLE or FIN, clear ERR_CNT, FIRST_ERR, DONE and PASS, set step to 0 and dwell counter to 0, and enter DRIVE on the next edge.
REQ-015 SHALL, in DRIVE, drive SW_OUT as the 4-bit step index replicated W/4 times (step 0 -> 000h, step 5 -> 555h, step 15 -> FFFh for W=12).
REQ-016 SHALL hold each step for exactly DWELL cycles and compare LED_IN against SW_OUT on the cycle the dwell counter equals DWELL-1.
REQ-017 SHALL, on a compare mismatch, increment ERR_CNT by 1, and SHALL latch the step index into FIRST_ERR only when ERR_CNT was 0.
REQ-018 SHALL advance the step and reset the dwell counter after the compare cycle; after step 15, SHALL enter FIN.
REQ-019 SHALL, in FIN, drive SW_OUT to 0, assert DONE, and set PASS = (ERR_CNT == 0).
REQ-020 SHALL make the sweep take exactly 16*DWELL cycles from the first DRIVE cycle to the first FIN cycle.
REQ-021 SHALL ignore START while in DRIVE; a running sweep is never restarted.
REQ-022 SHALL assert BUSY exactly when the state is DRIVE.
REQ-023 SHALL hold SW_OUT at 0 in IDLE.
REQ-024 SHALL have no carry-out beyond 16 errors; a 5-bit ERR_CNT is sufficient.
REQ-025 SHALL handle the step counter wrapping from 15 to 0 on the same edge as the FIN transition, with no extra step driven.

Reset
REQ-026 SHALL, on RST_N low, immediately set state IDLE, SW_OUT 0, BUSY 0, DONE 0, PASS 0, ERR_CNT 0, FIRST_ERR 0, and step and dwell counters 0.
REQ-027 SHALL, on reset mid-sweep, abandon the sweep with no DONE; it SHALL restart only on a fresh START after release.

Structure
REQ-028 SHALL place the state enum, NUM_STEPS=16, and the pattern-replication function in a shared package, pattern_sweep_pkg.
REQ-029 SHALL use one natural sub-module, dwell_timer: a loadable down- or up-counter with a terminal-count pulse, parameterised by DWELL.

Verification
REQ-030 SHALL cover loopback with LED_IN tied to SW_OUT, DWELL=10, and a START pulse; the required response is SW_OUT stepping 000h..FFFh, each step held 10 cycles, then DONE=1, PASS=1, ERR_CNT=0 at cycle 160.
REQ-031 SHALL cover a stuck bit with LED_IN = SW_OUT AND 7FFh; the required response is mismatches at steps 8..15, ERR_CNT=8, FIRST_ERR=8, PASS=0.
REQ-032 SHALL cover a single glitch by forcing LED_IN to 000h only during the compare cycle of step 3; the required response is ERR_CNT=1, FIRST_ERR=3, PASS=0.
REQ-033 SHALL cover START re-asserted at cycle 50 of a sweep; the required response is no restart, with DONE still occurring at cycle 160.
REQ-034 SHALL cover RST_N pulsed low at cycle 70 followed by a new START; the required response is all outputs 0 during reset and a full clean sweep afterward with PASS=1.
REQ-035 SHALL cover DWELL=2 with loopback; the required response is a 32-cycle sweep with PASS=1.
